// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared definitions for the load/store access unit: operation codes,
// FSM state encodings, the default ready-wait limit and the effective
// address helper.
package mem_access_unit_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_LDI = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Effective address: plain 32-bit modulo sum, carry-out dropped.
  function automatic logic [DATA_W-1:0] eff_addr(input logic [DATA_W-1:0] base,
                                                 input logic [DATA_W-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the request side (start/op/base/offset/st_data -> result/done/
// busy/err) and the memory side (mem_addr/mem_rd/mem_wr/mem_wdata ->
// mem_ready/mem_rdata) of the access unit.
//
// Handshake rules:
//   - start is a one-cycle request; it is accepted only when busy=0 and
//     ignored otherwise (no queuing).
//   - done pulses for exactly one cycle per accepted request; err is valid
//     in that cycle and stays set until reset or the next accepted start.
//   - mem_rd / mem_wr are held high (never both) for every cycle of the
//     access until the memory answers with a one-cycle mem_ready; read data
//     on mem_rdata is valid only while mem_ready=1.
//
// master: requester plus memory model (the environment).
// slave : the access unit itself.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic [1:0]        op;
  logic [31:0]       base;
  logic [31:0]       offset;
  logic [31:0]       st_data;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       result;
  logic              done;
  logic              busy;
  logic              err;

  modport master (
    output start, op, base, offset, st_data, mem_ready, mem_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, result, done, busy, err
  );

  modport slave (
    input  start, op, base, offset, st_data, mem_ready, mem_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata, result, done, busy, err
  );
endinterface

// File: rtl/mem_access_unit_register.sv
// register
// Generic register with load enable and asynchronous active-low clear.
// Used for the MAR and MDR of the access unit.
// Ports:
//   clk  - clock
//   clr  - asynchronous active-low clear (q -> 0)
//   en   - load enable; q takes d on the rising edge when high
//   d    - data in
//   q    - registered contents
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory access unit for LD / ST / LDI. Computes EA = base + offset, loads
// the MAR with the word address, then either returns EA (LDI) or performs a
// single memory read/write and waits for mem_ready, with a bounded wait that
// ends in a fault.
// Ports:
//   clk       - clock, rising edge
//   clr       - asynchronous active-low reset
//   bus       - request + memory signals (mem_access_unit_if.slave)
//   dbg_state - current FSM state for observation
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  mem_access_unit_if.slave    bus,
  output state_e              dbg_state
);

  // Counter must be able to hold TIMEOUT itself.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       offset_q, offset_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  logic [31:0]       ea;
  logic              mar_en;
  logic              mdr_en;
  logic [ADDR_W-1:0] mar_q;
  logic [31:0]       mdr_q;

  assign ea = eff_addr(base_q, offset_q);

  // MAR only keeps the word-address bits; higher EA bits wrap away.
  register #(.WIDTH(ADDR_W)) u_mar (
    .clk (clk),
    .clr (clr),
    .en  (mar_en),
    .d   (ea[ADDR_W-1:0]),
    .q   (mar_q)
  );

  // MDR captures store data at the accepting start and holds it throughout.
  register #(.WIDTH(32)) u_mdr (
    .clk (clk),
    .clr (clr),
    .en  (mdr_en),
    .d   (bus.st_data),
    .q   (mdr_q)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    base_d   = base_q;
    offset_d = offset_q;
    result_d = result_q;
    err_d    = err_q;
    wait_d   = wait_q;
    mar_en   = 1'b0;
    mdr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (op_e'(bus.op) == OP_RSV) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_ADDR;
            op_d     = op_e'(bus.op);
            base_d   = bus.base;
            offset_d = bus.offset;
            mdr_en   = 1'b1;
            err_d    = 1'b0;
          end
        end
      end

      ST_ADDR: begin
        mar_en = 1'b1;
        wait_d = '0;
        if (op_q == OP_LDI) begin
          state_d  = ST_DONE;
          result_d = ea;
        end else begin
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // mem_ready is checked first so it wins over a coincident timeout.
        if (bus.mem_ready) begin
          state_d = ST_DONE;
          if (op_q == OP_LD) result_d = bus.mem_rdata;
        end else begin
          wait_d = wait_q + CNT_W'(1);
          // wait_q counts completed unanswered cycles; this is the
          // TIMEOUT-th one without an answer.
          if (wait_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LD;
      base_q   <= '0;
      offset_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      result_q <= result_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset removes them without waiting for a clock edge.
  assign bus.mem_rd    = (state_q == ST_ACCESS) && (op_q == OP_LD);
  assign bus.mem_wr    = (state_q == ST_ACCESS) && (op_q == OP_ST);
  assign bus.mem_addr  = mar_q;
  assign bus.mem_wdata = mdr_q;
  assign bus.result    = result_q;
  assign bus.done      = (state_q == ST_DONE) || (state_q == ST_FAULT);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int ADDR_W = 9;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] st_data;
    logic [31:0] rdata;
    int          ready_k;     // ACCESS cycle that gets mem_ready, 0 = never
    bit          poke;        // fire extra starts while busy
    logic [8:0]  exp_addr;
    logic [31:0] exp_result;
    bit          exp_err;
    int          exp_lat;
    int          exp_strb;
  } vec_t;

  logic   clk;
  logic   clr;
  state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];     // {err, result}
  logic [31:0] model_result;

  vec_t tbl[9];

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] base,
                              input logic [31:0] offset, input logic [31:0] st_data,
                              input logic [31:0] rdata, input int k, input bit poke,
                              input logic [8:0] ea, input logic [31:0] res,
                              input bit er, input int lat, input int strb);
    vec_t v;
    v.op = op; v.base = base; v.offset = offset; v.st_data = st_data;
    v.rdata = rdata; v.ready_k = k; v.poke = poke; v.exp_addr = ea;
    v.exp_result = res; v.exp_err = er; v.exp_lat = lat; v.exp_strb = strb;
    return v;
  endfunction

  // ---------------- driver + memory model + monitor ----------------
  task automatic run_txn(input vec_t v);
    int lat;
    int strb;
    bit seen;
    logic [32:0] e;
    logic [31:0] kind;
    kind = (v.op == OP_LD) ? 32'd2 : (v.op == OP_ST) ? 32'd1 : 32'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = v.op; bus.base = v.base; bus.offset = v.offset;
    bus.st_data = v.st_data; bus.mem_ready = 1'b0;
    exp_q.push_back({v.exp_err, v.exp_result});
    lat = 0; strb = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      if (v.poke) begin
        bus.start = 1'b1; bus.op = 2'($urandom_range(0, 3));
        bus.base = $urandom; bus.offset = $urandom; bus.st_data = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.mem_rd || bus.mem_wr) begin
        strb++;
        chk("strobe_kind", 32'({bus.mem_rd, bus.mem_wr}), kind);
        chk("access_addr", 32'(bus.mem_addr), 32'(v.exp_addr));
        if (v.op == OP_ST) chk("access_wdata", bus.mem_wdata, v.st_data);
        if (strb == v.ready_k) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = v.rdata;
        end
      end
      if (bus.done) begin
        seen = 1'b1;
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("strobe_cycles", 32'(strb), 32'(v.exp_strb));
        chk("busy_at_done", 32'(bus.busy), 32'd1);
        chk("addr_at_done", 32'(bus.mem_addr), 32'(v.exp_addr));
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underflow: got done expected none");
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.result, e[31:0]);
          chk("err", 32'(bus.err), 32'(e[32]));
        end
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
    @(negedge clk);
    bus.start = 1'b0; bus.mem_ready = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_after", 32'(bus.busy), 32'd0);
    model_result = v.exp_result;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] b, o, s, r, sum, res;
    logic [1:0]  op;
    int          k;
    vec_t        v;

    // Stimulus table with hand-derived expectations.
    tbl[0] = mk(OP_LD,  32'h10,       32'h5,        32'h0,        32'hDEADBEEF, 1,  0, 9'h015, 32'hDEADBEEF, 0, 3,  1);
    tbl[1] = mk(OP_ST,  32'h0,        32'h1FF,      32'h12345678, 32'h0,        5,  0, 9'h1FF, 32'hDEADBEEF, 0, 7,  5);
    tbl[2] = mk(OP_LDI, 32'hFFFFFFFF, 32'h2,        32'h0,        32'h0,        0,  0, 9'h001, 32'h00000001, 0, 2,  0);
    tbl[3] = mk(OP_LD,  32'h100,      32'h7FFFFF10, 32'h0,        32'h11111111, 0,  0, 9'h010, 32'h00000001, 1, 17, 15);
    tbl[4] = mk(OP_LD,  32'h0,        32'hABC,      32'h0,        32'hCAFEF00D, 15, 0, 9'h0BC, 32'hCAFEF00D, 0, 17, 15);
    tbl[5] = mk(OP_RSV, 32'h55,       32'h55,       32'h0,        32'h0,        0,  0, 9'h0BC, 32'hCAFEF00D, 1, 1,  0);
    tbl[6] = mk(OP_LD,  32'h10000003, 32'hFFFFFFFE, 32'h0,        32'h0BADF00D, 2,  1, 9'h001, 32'h0BADF00D, 0, 4,  2);
    tbl[7] = mk(OP_ST,  32'h200,      32'h3,        32'hA5A5A5A5, 32'h0,        3,  1, 9'h003, 32'h0BADF00D, 0, 5,  3);
    tbl[8] = mk(OP_LDI, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        0,  1, 9'h000, 32'h00000000, 0, 2,  0);

    // Reset.
    clr = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.base = '0; bus.offset = '0;
    bus.st_data = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    model_result = '0;
    #3;
    chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_err",    32'(bus.err), 32'd0);
    chk("rst_rdwr",   32'({bus.mem_rd, bus.mem_wr}), 32'd0);
    chk("rst_addr",   32'(bus.mem_addr), 32'd0);
    chk("rst_wdata",  bus.mem_wdata, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // Random LD / ST / LDI with a reference model.
    for (int i = 0; i < 8; i++) begin
      op  = 2'($urandom_range(0, 2));
      b   = $urandom; o = $urandom; s = $urandom; r = $urandom;
      k   = $urandom_range(1, 4);
      sum = b + o;
      res = (op == OP_LDI) ? sum : (op == OP_LD) ? r : model_result;
      v   = mk(op, b, o, s, r, (op == OP_LDI) ? 0 : k, 1'($urandom_range(0, 1)),
               sum[8:0], res, 0, (op == OP_LDI) ? 2 : 2 + k, (op == OP_LDI) ? 0 : k);
      run_txn(v);
    end

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_LD; bus.base = 32'h20; bus.offset = 32'h3;
    bus.st_data = 32'h77; bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_rd",   32'(bus.mem_rd), 32'd1);
    chk("pre_rst_addr", 32'(bus.mem_addr), 32'h023);
    #2 clr = 1'b0;
    #1;
    chk("arst_rd",     32'(bus.mem_rd), 32'd0);
    chk("arst_wr",     32'(bus.mem_wr), 32'd0);
    chk("arst_busy",   32'(bus.busy), 32'd0);
    chk("arst_done",   32'(bus.done), 32'd0);
    chk("arst_addr",   32'(bus.mem_addr), 32'd0);
    chk("arst_wdata",  bus.mem_wdata, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_state",  32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    chk("arst_no_done", 32'(bus.done), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(bus.done), 32'd0);
    run_txn(mk(OP_LD, 32'h30, 32'h4, 32'h0, 32'h13579BDF, 1, 0, 9'h034, 32'h13579BDF, 0, 3, 1));

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
